hss_tx_framer: RTL
==================

Name: hss_tx_framer

Overview:
Parallel-side transmit framer for the 8:1 source-synchronous HSS link. It runs on the divided serializer clock and produces three 8-bit words per cycle for the data, sync and forwarded-clock OSERDESE3 lanes. Each cycle's words are framed as follows:
- a training counter pattern after link-up, then user data or idle words;
- a one-hot sync marker on every word boundary;
- an optional bit-level skew injection, so the receiver's sync-driven alignment gearbox can be exercised in bring-up.

Parameters:
TRAIN_WORDS, 64, number of counter-pattern words sent per training pass (1..65535)
IDLE_WORD, 8'hBC, word sent in DATA state when no valid input

Ports:
clk  in  1  divided (CLKDIV-rate) clock, same clock as the OSERDESE3 CLKDIV pins
rstn  in  1  asynchronous active-low reset
en  in  1  link enable; low forces OFF
train_req  in  1  single-cycle pulse: restart training
skew  in  3  bit delay (0..7) applied to the data and sync streams; sampled on entry to TRAIN
s_data  in  8  payload word, bit 0 serialized first
s_valid  in  1  payload valid
s_ready  out  1  payload accepted when s_valid & s_ready
oq_data  out  8  word to the data OSERDESE3 D
oq_sync  out  8  word to the sync OSERDESE3 D
oq_clk  out  8  word to the clock OSERDESE3 D
link_up  out  1  high while in DATA

Behaviour:
- Reset (rstn low, async): state OFF; all outputs 0; shifter history 0; latched skew 0; training count 0.
- States: OFF, TRAIN, DATA.
  - OFF->TRAIN when en=1. Latch skew; training count = 0.
  - TRAIN->DATA after TRAIN_WORDS words have been emitted, i.e. on the cycle the count equals TRAIN_WORDS-1.
  - TRAIN or DATA ->TRAIN on train_req (unless en=0). Relatch skew; count = 0.
  - Any state ->OFF when en=0. en=0 has priority over train_req.
- Stage 1 (registered) word select:
  - OFF: word 0, sync word 0.
  - TRAIN: word = count[7:0]; count increments each cycle, wrapping mod 256 on the value.
  - DATA: word = s_data if s_valid, else IDLE_WORD.
  - Sync word is 8'h01 in TRAIN and DATA.
- Stage 2 (registered) skew shifter on each stream:
  - out = ({cur, prev} << k)[15:8], where prev is the previous stage-1 word and k is the latched skew.
  - k=0 passes cur through.
  - Data and sync are always shifted identically, so the sync bit marks the true word boundary.
- Latency: a word accepted (or generated) in cycle N appears on oq_data in cycle N+2.
- s_ready:
  - Registered; 1 exactly while state is DATA, independent of s_valid.
  - Goes low the cycle after train_req or en falls. A word is lost only if offered in a cycle where s_ready=0.
- oq_clk: 8'hAA every cycle when not in reset, including OFF.
- link_up: registered, 1 while state==DATA.
- Skew changes while active are ignored until the next TRAIN entry.
- After OFF->TRAIN, prev=0, so the first k output bits are 0.

Optional Feature:
HSS_TX_STATS_EN:
- Defined: adds outputs data_cnt[31:0] (accepted payload words) and idle_cnt[31:0] (idle words sent in DATA).
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear on reset and on entry to TRAIN.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package hss_pkg:
  - SER_W=8
  - SYNC_WORD=8'h01
  - CLK_WORD=8'hAA
  - state enum hss_tx_state_t {OFF, TRAIN, DATA}
- Sub-module hss_bitslip:
  - 8-bit history register plus 16-bit shift mux, with clk/rstn/k/din/dout.
  - Instantiated twice, once for data and once for sync.

Test Plan:
1. Reset, skew=0, en=1 at cycle 0 -> oq_sync=0x01 and oq_data=0x00,0x01,...,0x3F starting cycle 2; oq_clk=0xAA throughout; s_ready and link_up rise after the 64th training word is emitted.
2. skew=3, stage-1 words 0x05 then 0x06 -> oq_data=0x30 (from 0x0605<<3) and oq_sync=0x08 on the cycle of word 0x06.
3. DATA state: s_valid=1/0xA5, then s_valid=0 for 2 cycles -> oq_data=0xA5, 0xBC, 0xBC at 2-cycle latency; sync stays 0x01.
4. train_req pulse in DATA -> s_ready=0 next cycle, oq_data restarts at 0x00 two cycles later, link_up low until 64 words are emitted.
5. rstn low mid-TRAIN, asynchronous to clk -> all outputs 0 immediately; after release with en=1, training restarts at 0x00.
6. en low mid-TRAIN with train_req simultaneously high -> OFF: oq_sync=0, oq_data=0, oq_clk stays 0xAA; with HSS_TX_STATS_EN, counters hold until the next TRAIN entry.

Source files
------------

// File: rtl/hss_pkg.sv
// hss_pkg: shared widths, framing constants and transmit state type for the HSS link.
package hss_pkg;
  localparam int SER_W = 8;
  localparam logic [SER_W-1:0] SYNC_WORD = 8'h01;
  localparam logic [SER_W-1:0] CLK_WORD = 8'hAA;
  typedef enum logic [1:0] {OFF, TRAIN, DATA} hss_tx_state_t;
endpackage

// File: rtl/hss_bitslip.sv
// hss_bitslip: delays a word stream by k bits using the previous word as history.
module hss_bitslip
  import hss_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       k,
  input  logic [SER_W-1:0] din,
  output logic [SER_W-1:0] dout
);
  logic [SER_W-1:0]   hist_q, hist_d, dout_q, dout_d;
  logic [2*SER_W-1:0] sh;
  always_comb begin
    sh = {din, hist_q} << k;
    dout_d = sh[2*SER_W-1:SER_W];
    hist_d = din;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
      dout_q <= '0;
    end else begin
      hist_q <= hist_d;
      dout_q <= dout_d;
    end
  end
  assign dout = dout_q;
endmodule

// File: rtl/hss_tx_framer.sv
// hss_tx_framer: training/data/idle word framer with sync marker and skew injection.
// Optional HSS_TX_STATS_EN adds saturating accepted-data and idle-word counters.
module hss_tx_framer
  import hss_pkg::*;
#(
  parameter int unsigned      TRAIN_WORDS = 64,
  parameter logic [SER_W-1:0] IDLE_WORD   = 8'hBC
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             train_req,
  input  logic [2:0]       skew,
  input  logic [SER_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [SER_W-1:0] oq_data,
  output logic [SER_W-1:0] oq_sync,
  output logic [SER_W-1:0] oq_clk,
  output logic             link_up
`ifdef HSS_TX_STATS_EN
  ,
  output logic [31:0]      data_cnt,
  output logic [31:0]      idle_cnt
`endif
);
  hss_tx_state_t    state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       k_q, k_d;
  logic [SER_W-1:0] word_q, word_d, sync_q, sync_d, clk_q;
  logic             up_q, up_d, enter_train;
  always_comb begin
    state_d = state_q;
    if (!en) state_d = OFF;
    else if (state_q == OFF || train_req) state_d = TRAIN;
    else if (state_q == TRAIN && cnt_q == 16'(TRAIN_WORDS - 1)) state_d = DATA;
    enter_train = en && (state_q == OFF || train_req);
    k_d = enter_train ? skew : k_q;
    cnt_d = enter_train ? 16'd0 : (state_q == TRAIN ? cnt_q + 16'd1 : cnt_q);
    word_d = state_q == TRAIN ? cnt_q[SER_W-1:0] :
             state_q == DATA ? (s_valid ? s_data : IDLE_WORD) : '0;
    sync_d = state_q == OFF ? '0 : SYNC_WORD;
    up_d = state_d == DATA;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= OFF;
      cnt_q   <= '0;
      k_q     <= '0;
      word_q  <= '0;
      sync_q  <= '0;
      clk_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      word_q  <= word_d;
      sync_q  <= sync_d;
      clk_q   <= CLK_WORD;
      up_q    <= up_d;
    end
  end
  // Both streams share k so the sync bit stays on the true word boundary.
  hss_bitslip u_slip_data (.clk(clk), .rstn(rstn), .k(k_q), .din(word_q), .dout(oq_data));
  hss_bitslip u_slip_sync (.clk(clk), .rstn(rstn), .k(k_q), .din(sync_q), .dout(oq_sync));
  assign oq_clk  = clk_q;
  assign s_ready = up_q;
  assign link_up = up_q;
`ifdef HSS_TX_STATS_EN
  logic [31:0] data_cnt_q, data_cnt_d, idle_cnt_q, idle_cnt_d;
  always_comb begin
    data_cnt_d = enter_train ? '0 :
                 (state_q == DATA && s_valid && data_cnt_q != '1) ? data_cnt_q + 32'd1 : data_cnt_q;
    idle_cnt_d = enter_train ? '0 :
                 (state_q == DATA && !s_valid && idle_cnt_q != '1) ? idle_cnt_q + 32'd1 : idle_cnt_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      data_cnt_q <= data_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
  assign data_cnt = data_cnt_q;
  assign idle_cnt = idle_cnt_q;
`endif
endmodule
